// File: rtl/rotation_tracker.sv
// rotation_tracker: IR-edge rotor period and slice-angle tracker; define ROT_TRACKER_AVG_EN to report a 4-deep mean period
module rotation_tracker #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int PERIOD_WIDTH   = 24,
  parameter int MIN_PERIOD     = 1000,
  parameter int MAX_PERIOD     = 2**24-1
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              ir_tripped,
  output logic [$clog2(ROTATIONAL_RES)-1:0] theta,
  output logic                              theta_tick,
  output logic                              theta_valid,
  output logic                              rev_tick,
  output logic [PERIOD_WIDTH-1:0]           period
);
  localparam int TW = $clog2(ROTATIONAL_RES);
  localparam logic [1:0] IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2;
  localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] MAX_P = PERIOD_WIDTH'(MAX_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);
  localparam logic [TW-1:0] THETA_MAX = TW'(ROTATIONAL_RES-1);
  logic [1:0] state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, slice_q, slice_d, period_q, period_d;
  logic [PERIOD_WIDTH-1:0] sl_raw, slice_len, new_period;
  logic [TW-1:0] theta_q, theta_d;
  logic theta_tick_q, theta_tick_d, rev_tick_q, rev_tick_d, ir_q, ir_d;
  logic rise, timeout, accept;
`ifdef ROT_TRACKER_AVG_EN
  localparam int SW = PERIOD_WIDTH + 2;
  logic [3:0][PERIOD_WIDTH-1:0] hist_q, hist_d, hist_n;
  logic [SW-1:0] sum;
`endif
  always_comb begin
    ir_d = ir_tripped;
    rise = ir_tripped & ~ir_q;
    timeout = state_q != IDLE && cnt_q == MAX_P;
    accept = state_q != IDLE && rise && cnt_q >= MIN_P && !timeout;
    sl_raw = period_q >> TW;
    slice_len = sl_raw == '0 ? ONE : sl_raw;
`ifdef ROT_TRACKER_AVG_EN
    // first lock seeds the whole history so the mean starts at the first measurement
    hist_n = state_q == ACQUIRE ? {4{cnt_q}} : {hist_q[2:0], cnt_q};
    sum = SW'(hist_n[0]) + SW'(hist_n[1]) + SW'(hist_n[2]) + SW'(hist_n[3]);
    new_period = sum[SW-1:2];
    hist_d = accept ? hist_n : hist_q;
`else
    new_period = cnt_q;
`endif
    state_d = state_q;
    cnt_d = cnt_q;
    slice_d = slice_q;
    theta_d = theta_q;
    period_d = period_q;
    theta_tick_d = 1'b0;
    rev_tick_d = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      cnt_d = '0;
      slice_d = '0;
      theta_d = '0;
    end else if (state_q == IDLE) begin
      state_d = rise ? ACQUIRE : IDLE;
      cnt_d = rise ? ONE : '0;
    end else if (accept) begin
      state_d = LOCKED;
      cnt_d = ONE;
      slice_d = '0;
      theta_d = '0;
      period_d = new_period;
      theta_tick_d = 1'b1;
      rev_tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE;
      if (state_q == LOCKED) begin
        slice_d = slice_q == slice_len - ONE ? '0 : slice_q + ONE;
        theta_tick_d = slice_q == slice_len - ONE && theta_q != THETA_MAX;
        theta_d = theta_tick_d ? theta_q + TW'(1) : theta_q;
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      slice_q <= '0;
      theta_q <= '0;
      period_q <= '0;
      theta_tick_q <= 1'b0;
      rev_tick_q <= 1'b0;
      ir_q <= 1'b0;
`ifdef ROT_TRACKER_AVG_EN
      hist_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      slice_q <= slice_d;
      theta_q <= theta_d;
      period_q <= period_d;
      theta_tick_q <= theta_tick_d;
      rev_tick_q <= rev_tick_d;
      ir_q <= ir_d;
`ifdef ROT_TRACKER_AVG_EN
      hist_q <= hist_d;
`endif
    end
  end
  assign theta = theta_q;
  assign theta_tick = theta_tick_q;
  assign theta_valid = state_q == LOCKED;
  assign rev_tick = rev_tick_q;
  assign period = period_q;
endmodule

// File: tb/tb_rotation_tracker.sv
// tb_rotation_tracker: randomized edge trains checked against a timestamp-based reference model
module tb_rotation_tracker;
  localparam int RES = 16, MINP = 8, MAXP = 4096, PW = 24;
  logic clk = 1'b0, rst = 1'b1, ir = 1'b0;
  logic [3:0] theta;
  logic theta_tick, theta_valid, rev_tick;
  logic [PW-1:0] period;
  int vectors = 0, miscompares = 0;
  int n = 0, mode = 0, t_start = 0, per = 0;
  bit prev = 1'b0;
  int hist[$];
  rotation_tracker #(
    .ROTATIONAL_RES(RES), .PERIOD_WIDTH(PW), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)
  ) dut (
    .clk_in(clk), .rst_in(rst), .ir_tripped(ir), .theta(theta), .theta_tick(theta_tick),
    .theta_valid(theta_valid), .rev_tick(rev_tick), .period(period)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask
  // mode 0 idle, 1 acquiring, 2 locked; t_start is the cycle the running count restarted at 1
  task automatic model_step(input bit r, input bit i);
    int c;
    bit ed;
    if (r) begin
      mode = 0; per = 0; prev = 1'b0; t_start = n;
      hist.delete();
      return;
    end
    c = n - t_start;
    ed = i && !prev;
    prev = i;
    if (mode != 0 && c == MAXP) mode = 0;
    else if (mode == 0) begin
      if (ed) begin mode = 1; t_start = n; end
    end else if (ed && c >= MINP) begin
`ifdef ROT_TRACKER_AVG_EN
      if (mode == 1) hist = '{c, c, c, c};
      else begin hist.push_back(c); void'(hist.pop_front()); end
      per = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
      per = c;
`endif
      mode = 2;
      t_start = n;
    end
  endtask
  task automatic cyc(input bit i, input bit r);
    int k, sl, e_th;
    bit e_tt, e_rev;
    ir = i;
    rst = r;
    @(posedge clk);
    n++;
    model_step(r, i);
    #1;
    e_th = 0; e_tt = 1'b0; e_rev = 1'b0;
    if (mode == 2) begin
      k = n - t_start;
      sl = (per / RES) == 0 ? 1 : per / RES;
      e_th = (k / sl) > RES - 1 ? RES - 1 : k / sl;
      e_tt = k == 0 || (k % sl == 0 && k / sl <= RES - 1);
      e_rev = k == 0;
    end
    check("theta", 32'(theta), e_th);
    check("theta_tick", 32'(theta_tick), 32'(e_tt));
    check("theta_valid", 32'(theta_valid), 32'(mode == 2));
    check("rev_tick", 32'(rev_tick), 32'(e_rev));
    check("period", 32'(period), per);
  endtask
  task automatic edge_train(input int iv, input int cnt);
    repeat (cnt) begin
      cyc(1'b1, 1'b0);
      repeat (iv - 1) cyc(1'b0, 1'b0);
    end
  endtask
  initial begin
    repeat (6) cyc(1'($urandom), 1'b1);
    cyc(1'b0, 1'b0);
    edge_train(160, 5);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
    repeat (156) cyc(1'b0, 1'b0);
    edge_train(160, 2);
    repeat (4200) cyc(1'b0, 1'b0);
    edge_train(160, 3);
    edge_train(320, 2);
    edge_train(160, 1);
    repeat (60) edge_train($urandom_range(0, 3) == 0 ? $urandom_range(2, 40) : $urandom_range(8, 400), 1);
    edge_train(100, 3);
    repeat (30) cyc(1'b0, 1'b0);
    repeat (2) cyc(1'($urandom), 1'b1);
    cyc(1'b0, 1'b0);
    edge_train(100, 3);
    cyc(1'b1, 1'b0);
    repeat (4095) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b0);
    edge_train(20, 4);
    edge_train(12, 3);
    repeat (40) cyc(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rotation_tracker.md
ROTATION_TRACKER -- requirements
Module: rotation_tracker

Interface
REQ-001 SHALL have parameter ROTATIONAL_RES, default 1024, slices per revolution, power of two, >= 4.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 24, width of the period counter and the period output.
REQ-003 SHALL have parameter MIN_PERIOD, default 1000, minimum accepted cycles between IR edges; closer edges are glitches.
REQ-004 SHALL have parameter MAX_PERIOD, default 2**24-1, counter value at which the rotor is declared stopped.
REQ-005 SHALL have port clk_in, input, 1, the single clock, sysclk domain.
REQ-006 SHALL have port rst_in, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port ir_tripped, input, 1, debounced and synchronised IR sensor level.
REQ-008 SHALL have port theta, output, $clog2(ROTATIONAL_RES), current slice index.
REQ-009 SHALL have port theta_tick, output, 1, one-cycle pulse whenever theta is loaded or advanced.
REQ-010 SHALL have port theta_valid, output, 1, high only in LOCKED.
REQ-011 SHALL have port rev_tick, output, 1, one-cycle pulse on each accepted edge that leaves the block in LOCKED.
REQ-012 SHALL have port period, output, PERIOD_WIDTH, clock cycles per revolution.

Function
REQ-013 SHALL detect a rising edge as ir_tripped high while the registered previous sample is low; all outputs respond on the following clock edge.
REQ-014 SHALL implement states IDLE, ACQUIRE and LOCKED.
REQ-015 IDLE: counter held at 0; a rising edge loads counter=1 and moves to ACQUIRE.
REQ-016 ACQUIRE/LOCKED: counter increments by 1 per cycle.
REQ-017 ACQUIRE/LOCKED: an edge is accepted only if counter >= MIN_PERIOD; rejected edges cause no change to any register except the edge-detect register.
REQ-018 Accepted edge: measured period = counter value; counter reloads to 1; state becomes LOCKED; theta=0; slice counter=0; theta_tick=1; rev_tick=1.
REQ-019 slice_len SHALL be period >> log2(ROTATIONAL_RES), clamped to a minimum of 1.
REQ-020 LOCKED, no accepted edge: slice counter increments; when it equals slice_len-1 it clears, theta increments, theta_tick pulses.
REQ-021 theta SHALL saturate at ROTATIONAL_RES-1, with no tick while saturated, until the next accepted edge; it SHALL never wrap to 0 except on an accepted edge.
REQ-022 counter == MAX_PERIOD in ACQUIRE/LOCKED SHALL force IDLE with theta=0, theta_valid=0, period held; timeout has priority over a same-cycle edge.
REQ-023 An accepted edge SHALL have priority over a same-cycle slice boundary.
REQ-024 theta_tick and rev_tick SHALL never be high for more than one consecutive cycle, except theta_tick when slice_len=1.

Reset
REQ-025 rst_in high SHALL on the next clock edge force IDLE, counter=0, slice counter=0, theta=0, theta_tick=0, theta_valid=0, rev_tick=0, period=0, edge-detect register=0, and clear the averaging history.
REQ-026 Reset asserted mid-revolution SHALL discard the partial measurement; the first edge after reset only enters ACQUIRE.

Configuration
REQ-027 With ROT_TRACKER_AVG_EN defined, period SHALL be the mean of the last 4 measured periods (sum >> 2, truncating); on ACQUIRE->LOCKED all 4 history entries SHALL load with the first measurement.
REQ-028 Without ROT_TRACKER_AVG_EN, period SHALL be the latest measured period and no history registers SHALL exist.

Verification (ROTATIONAL_RES=16, MIN_PERIOD=8, MAX_PERIOD=4096)
REQ-029 Reset with ir_tripped toggling -> all outputs 0, state IDLE for the entire reset duration.
REQ-030 Edges every 160 cycles -> theta_valid rises after the 2nd edge, period=160, theta advances every 10 cycles and reaches 15; 16 theta_tick pulses and 1 rev_tick per revolution.
REQ-031 Extra edge 3 cycles after an accepted edge -> ignored; theta sequence and period unchanged.
REQ-032 Edges stop after lock -> IDLE 4096 cycles after the last edge; theta_valid=0, theta=0, period holds 160.
REQ-033 Raw mode, period jumps from 160 to 320 -> theta holds at 15 from cycle 150 until the next edge, then returns to 0 with period=320.
REQ-034 ROT_TRACKER_AVG_EN, measured periods 160,160,160,200 -> period = 170 after the 4th measurement.
